// File: rtl/inertial_sensor_intf.sv
// IMU sequencer: power-up delay, four configuration writes, then a four-byte
// read of pitch rate and Z acceleration on every data-ready interrupt.
module inertial_sensor_intf #(
  parameter int INIT_WAIT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  typedef enum logic [3:0] {
    INIT_WAIT, CFG0, CFG1, CFG2, CFG3, IDLE, RD0, RD1, RD2, RD3, VALID
  } state_t;

  localparam logic [INIT_WAIT_W-1:0] TIMER_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

  state_t                 state_reg, state_next;
  logic                   int_ff1_reg, int_s_reg;
  logic [INIT_WAIT_W-1:0] timer_reg;
  logic [7:0]             pl_reg, ph_reg, al_reg;
  logic                   wrt_reg;
  logic [15:0]            cmd_reg, ptch_reg, az_reg;
  logic                   start_next;
  logic [15:0]            cmd_next;
  logic                   done_ok;
  logic                   timer_tc;
  logic [7:0]             rd_hi_unused;

  assign rd_hi_unused = rd_data[15:8];

  // A done arriving while wrt is still high belongs to no transaction of ours.
  assign done_ok  = done & ~wrt_reg;
  assign timer_tc = &timer_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= INIT_WAIT;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT_WAIT: if (timer_tc)  state_next = CFG0;
      CFG0:      if (done_ok)   state_next = CFG1;
      CFG1:      if (done_ok)   state_next = CFG2;
      CFG2:      if (done_ok)   state_next = CFG3;
      CFG3:      if (done_ok)   state_next = IDLE;
      IDLE:      if (int_s_reg) state_next = RD0;
      RD0:       if (done_ok)   state_next = RD1;
      RD1:       if (done_ok)   state_next = RD2;
      RD2:       if (done_ok)   state_next = RD3;
      RD3:       if (done_ok)   state_next = VALID;
      VALID:                    state_next = IDLE;
      default:                  state_next = INIT_WAIT;
    endcase
  end

  // Transaction start and its command are decided from the state being entered.
  always_comb begin
    vld        = (state_reg == VALID);
    start_next = 1'b0;
    cmd_next   = 16'h0000;
    if (state_next != state_reg) begin
      case (state_next)
        CFG0:    begin start_next = 1'b1; cmd_next = 16'h0D02; end
        CFG1:    begin start_next = 1'b1; cmd_next = 16'h1053; end
        CFG2:    begin start_next = 1'b1; cmd_next = 16'h1150; end
        CFG3:    begin start_next = 1'b1; cmd_next = 16'h1460; end
        RD0:     begin start_next = 1'b1; cmd_next = 16'hA200; end
        RD1:     begin start_next = 1'b1; cmd_next = 16'hA300; end
        RD2:     begin start_next = 1'b1; cmd_next = 16'hAC00; end
        RD3:     begin start_next = 1'b1; cmd_next = 16'hAD00; end
        default: begin start_next = 1'b0; cmd_next = 16'h0000; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_reg <= 1'b0;
      int_s_reg   <= 1'b0;
      timer_reg   <= '0;
      wrt_reg     <= 1'b0;
      cmd_reg     <= 16'h0000;
      pl_reg      <= 8'h00;
      ph_reg      <= 8'h00;
      al_reg      <= 8'h00;
      ptch_reg    <= 16'h0000;
      az_reg      <= 16'h0000;
    end else begin
      int_ff1_reg <= INT;
      int_s_reg   <= int_ff1_reg;
      wrt_reg     <= start_next;
      if (start_next) cmd_reg <= cmd_next;
      if (state_reg == INIT_WAIT) timer_reg <= timer_reg + TIMER_ONE;
      if (done_ok) begin
        case (state_reg)
          RD0: pl_reg <= rd_data[7:0];
          RD1: ph_reg <= rd_data[7:0];
          RD2: al_reg <= rd_data[7:0];
          // High AZ byte goes straight to the output so both words land together.
          RD3: begin
            ptch_reg <= {ph_reg, pl_reg};
            az_reg   <= {rd_data[7:0], al_reg};
          end
          default: ;
        endcase
      end
    end
  end

  assign wrt     = wrt_reg;
  assign cmd     = cmd_reg;
  assign ptch_rt = ptch_reg;
  assign AZ      = az_reg;

endmodule

// File: tb/tb_inertial_sensor_intf.sv
// Directed bench: SPI responder answers each wrt after 20 cycles and also
// pulses done during the wrt cycle itself, which the DUT must ignore.
module tb_inertial_sensor_intf;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rst_events  = 0;
  int vld_cnt     = 0;
  int wrt_cnt     = 0;
  int last_done_cyc = 0;
  int last_wrt_cyc  = 0;
  int vld_cyc       = 0;
  int spi_rst_snap;
  logic [7:0] spi_byte;
  logic [7:0] tab_pl, tab_ph, tab_al, tab_ah;

  inertial_sensor_intf #(.INIT_WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_events <= rst_events + 1;
  always @(posedge clk) begin
    #1;
    if (vld === 1'b1) vld_cnt++;
    if (wrt === 1'b1) wrt_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_for(input logic [15:0] c);
    case (c)
      16'hA200: return tab_pl;
      16'hA300: return tab_ph;
      16'hAC00: return tab_al;
      16'hAD00: return tab_ah;
      default:  return 8'h00;
    endcase
  endfunction

  // SPI master model; aborts an outstanding transaction on reset.
  initial begin
    done = 1'b0;
    rd_data = 16'h0000;
    forever begin
      if (wrt === 1'b1 && rst_n === 1'b1) begin
        spi_rst_snap = rst_events;
        spi_byte = byte_for(cmd);
        done = 1'b1;
        rd_data = 16'hDEAD;
        @(posedge clk); #1;
        done = 1'b0;
        for (int k = 0; k < 18; k++) begin
          @(posedge clk);
          if (rst_events != spi_rst_snap) break;
        end
        #1;
        if (rst_events == spi_rst_snap) begin
          done = 1'b1;
          rd_data = {~spi_byte, spi_byte};
          last_done_cyc = cyc;
          @(posedge clk); #1;
          done = 1'b0;
          rd_data = 16'h0000;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  task automatic wait_wrt(input string tag, input logic [15:0] exp_cmd, input int exp_gap);
    logic found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (wrt === 1'b1) begin found = 1'b1; break; end
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_cmd"}, {16'd0, cmd}, {16'd0, exp_cmd});
    if (exp_gap > 0) chk({tag, "_gap"}, cyc - last_wrt_cyc, exp_gap);
    $display("wrt  %-10s cmd=%04h cycle=%0d", tag, cmd, cyc);
    last_wrt_cyc = cyc;
  endtask

  task automatic wait_vld(input string tag, input logic [15:0] exp_p, input logic [15:0] exp_a);
    logic found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (vld === 1'b1) begin found = 1'b1; break; end
    end
    vld_cyc = cyc;
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_lat"}, vld_cyc - last_done_cyc, 1);
    chk({tag, "_ptch"}, {16'd0, ptch_rt}, {16'd0, exp_p});
    chk({tag, "_az"}, {16'd0, AZ}, {16'd0, exp_a});
    $display("vld  %-10s ptch_rt=%04h AZ=%04h cycle=%0d", tag, ptch_rt, AZ, cyc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wrt"}, {31'd0, wrt}, 32'd0);
    chk({tag, "_vld"}, {31'd0, vld}, 32'd0);
    chk({tag, "_cmd"}, {16'd0, cmd}, 32'd0);
    chk({tag, "_ptch"}, {16'd0, ptch_rt}, 32'd0);
    chk({tag, "_az"}, {16'd0, AZ}, 32'd0);
  endtask

  task automatic run_config(input int first_gap);
    wait_wrt("cfg0", 16'h0D02, first_gap);
    wait_wrt("cfg1", 16'h1053, 20);
    wait_wrt("cfg2", 16'h1150, 20);
    wait_wrt("cfg3", 16'h1460, 20);
  endtask

  int snap;

  initial begin
    rst_n = 1'b1;
    INT = 1'b0;
    tab_pl = 8'h34; tab_ph = 8'h12; tab_al = 8'hF0; tab_ah = 8'hFF;

    // Asynchronous reset asserted between clock edges
    #3 rst_n = 1'b0;
    #1 chk_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_wrt_cyc = cyc;

    run_config(16);
    repeat (30) @(posedge clk);
    #1;
    chk("init_no_vld", vld_cnt, 0);

    // Single read; INT pulse during RD1 must not queue a second sequence
    @(negedge clk) INT = 1'b1;
    wait_wrt("rd_pl", 16'hA200, 0);
    INT = 1'b0;
    wait_wrt("rd_ph", 16'hA300, 20);
    @(negedge clk) INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
    wait_wrt("rd_al", 16'hAC00, 20);
    wait_wrt("rd_ah", 16'hAD00, 20);
    wait_vld("rd1", 16'h1234, 16'hFFF0);
    @(posedge clk); #1;
    chk("rd1_vld_width", {31'd0, vld}, 32'd0);
    snap = wrt_cnt;
    repeat (60) @(posedge clk);
    #1;
    chk("no_requeue", wrt_cnt - snap, 0);
    chk("cmd_hold", {16'd0, cmd}, 32'h0000AD00);
    chk("data_hold", {ptch_rt, AZ}, 32'h1234FFF0);

    // INT held high: back-to-back sequences
    tab_pl = 8'h55; tab_ph = 8'hAA; tab_al = 8'h01; tab_ah = 8'h80;
    @(negedge clk) INT = 1'b1;
    wait_wrt("b2b_pl", 16'hA200, 0);
    wait_wrt("b2b_ph", 16'hA300, 20);
    wait_wrt("b2b_al", 16'hAC00, 20);
    wait_wrt("b2b_ah", 16'hAD00, 20);
    wait_vld("b2b1", 16'hAA55, 16'h8001);
    tab_pl = 8'h77; tab_ph = 8'h80; tab_al = 8'h00; tab_ah = 8'h7F;
    @(posedge clk); #1;
    chk("b2b1_vld_width", {31'd0, vld}, 32'd0);
    wait_wrt("b2b2_pl", 16'hA200, 0);
    chk("b2b_restart", cyc - vld_cyc, 2);
    INT = 1'b0;
    wait_wrt("b2b2_ph", 16'hA300, 20);
    wait_wrt("b2b2_al", 16'hAC00, 20);
    wait_wrt("b2b2_ah", 16'hAD00, 20);
    wait_vld("b2b2", 16'h8077, 16'h7F00);
    @(posedge clk); #1;
    chk("b2b2_vld_width", {31'd0, vld}, 32'd0);

    // Reset during RD2 with INT held high through the repeated power-up
    tab_pl = 8'h11; tab_ph = 8'h22; tab_al = 8'h33; tab_ah = 8'h44;
    @(negedge clk) INT = 1'b1;
    wait_wrt("mr_pl", 16'hA200, 0);
    wait_wrt("mr_ph", 16'hA300, 20);
    wait_wrt("mr_al", 16'hAC00, 20);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    snap = vld_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_wrt_cyc = cyc;
    run_config(16);
    chk("mr_no_vld", vld_cnt - snap, 0);
    chk("mr_stale", {ptch_rt, AZ}, 32'h0);
    wait_wrt("post_pl", 16'hA200, 21);
    wait_wrt("post_ph", 16'hA300, 20);
    INT = 1'b0;
    wait_wrt("post_al", 16'hAC00, 20);
    wait_wrt("post_ah", 16'hAD00, 20);
    wait_vld("post", 16'h2211, 16'h4433);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inertial_sensor_intf.md
Name: inertial_sensor_intf

Overview:
- Upstream stage of the inertial integrator. Sequences the IMU through an external SPI master using a wrt/done handshake.
- Runs a one-time power-up configuration. After that, on each IMU data-ready interrupt it reads pitch rate and Z acceleration.
- Assembles 16-bit samples and pulses vld for one cycle. ptch_rt, AZ and vld feed the integrator directly.

Parameters:
INIT_WAIT_W  16  width of power-up delay counter; delay = 2^INIT_WAIT_W clocks (bench overrides to 4)

Ports:
clk      input   1   system clock
rst_n    input   1   asynchronous active-low reset
INT      input   1   IMU data-ready interrupt, asynchronous, active-high level
done     input   1   SPI master transaction-complete, one-cycle pulse
rd_data  input   16  SPI master read data; valid when done=1; only [7:0] used
wrt      output  1   start-transaction pulse to SPI master
cmd      output  16  SPI command word; valid when wrt=1
vld      output  1   new sample pulse to integrator
ptch_rt  output  16  signed pitch rate {high byte, low byte}
AZ       output  16  signed Z acceleration {high byte, low byte}

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low: rst_n low immediately forces all flops to reset values, regardless of clk.
- Reset values:
  - wrt=0, vld=0, cmd=16'h0000, ptch_rt=0, AZ=0.
  - Holding registers=0, timer=0, INT synchronizer=0, state=INIT_WAIT.
- INT synchronizer:
  - Double-flopped to INT_s.
  - All decisions use INT_s only.
- Timer:
  - INIT_WAIT_W-bit up-counter, runs only in INIT_WAIT.
  - Terminal count is all ones.
- wrt:
  - Registered.
  - High for exactly one cycle, the first cycle of each CFG_n or RD_n state.
  - cmd is registered and loaded in the same cycle as wrt, then held until the next wrt.
- done:
  - In any CFG/RD state, the block waits indefinitely for done.
  - done in the same cycle as wrt is ignored; the block waits for a later done.
- States and transitions:
  - INIT_WAIT: timer at terminal count -> CFG0.
  - CFG0 cmd=16'h0D02 (enable data-ready INT); done -> CFG1.
  - CFG1 cmd=16'h1053 (accel 208 Hz); done -> CFG2.
  - CFG2 cmd=16'h1150 (gyro 208 Hz); done -> CFG3.
  - CFG3 cmd=16'h1460 (rounding); done -> IDLE.
  - IDLE: INT_s=1 -> RD0; otherwise stay.
  - RD0 cmd=16'hA200 (pitch rate low); done: capture rd_data[7:0] into pl -> RD1.
  - RD1 cmd=16'hA300 (pitch rate high); done: capture into ph -> RD2.
  - RD2 cmd=16'hAC00 (AZ low); done: capture into al -> RD3.
  - RD3 cmd=16'hAD00 (AZ high); done: capture into ah -> VALID.
  - VALID (one cycle):
    - vld=1.
    - ptch_rt={ph,pl} and AZ={ah,al}, updated on the clock edge that enters VALID, so they are stable while vld=1.
    - -> IDLE.
- Output hold: ptch_rt and AZ change only on entry to VALID, and are held otherwise.
- Interrupt handling:
  - INT activity outside IDLE is ignored and not queued.
  - If INT_s is still high on returning to IDLE, a new read sequence starts the next cycle.
- Latency: INT_s high in IDLE -> vld exactly 1 cycle after the 4th done.
- No data transfer before configuration completes: vld is never asserted before CFG3 completes, even if INT toggles during INIT_WAIT or CFG.
- Reset mid-operation: all state returns to INIT_WAIT, the full power-up delay and configuration repeat, and outputs return to 0.
- rd_data[15:8] is ignored.

Test Plan:
- Reset values:
  - Stimulus: assert rst_n=0 mid-cycle.
  - Response: wrt, vld, cmd, ptch_rt and AZ all 0 immediately (asynchronous); state INIT_WAIT.
- Init sequence:
  - Stimulus: INIT_WAIT_W=4; release reset; SPI model returns done 20 cycles after each wrt.
  - Response:
    - First wrt exactly 16 cycles after reset release, with cmd=16'h0D02.
    - Then 16'h1053, 16'h1150, 16'h1460 in order, one wrt pulse each.
    - No vld.
- Read sequence:
  - Stimulus: after init, INT=1; SPI model returns rd_data low bytes 8'h34, 8'h12, 8'hF0, 8'hFF.
  - Response:
    - cmds 16'hA200, 16'hA300, 16'hAC00, 16'hAD00, in that order.
    - vld high for one cycle, 1 cycle after the 4th done.
    - ptch_rt=16'h1234, AZ=16'hFFF0.
- Interrupt timing:
  - Stimulus: INT pulsed during RD1 then low.
  - Response: no second sequence.
  - Stimulus: INT held high.
  - Response: back-to-back sequences, each ending in a single vld.
- Pre-config INT:
  - Stimulus: INT=1 throughout INIT_WAIT and CFG states.
  - Response: first read command appears only after CFG3's done.
- Reset mid-read:
  - Stimulus: rst_n pulsed low during RD2.
  - Response:
    - Outputs 0.
    - Full 16-cycle delay and 4 config writes repeat before any read.
    - Stale bytes never appear on ptch_rt/AZ.
